uart_boot_loader: RTL



---
 rtl/uart_boot_loader.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_boot_loader
//
// Loads a program image into the CPU program BSRAM (single-port, 2048x16) from
// a UART RX line. The CPU is held in reset while loading. It is released once
// the image has been accepted, and it then fetches from address 0.
//
// Frame format (bytes, 8N1, LSB first):
//   SYNC_BYTE, N, {lo, hi} x N [, checksum]
// The checksum is the 8-bit wrapping sum of all data bytes. It is present only
// when the BOOT_CHECKSUM_EN macro is defined. Without the macro there is no
// checksum byte, and the loader goes straight to DONE after the last word.
//
// Ports:
//   clk          memory clock (same as BSRAM clk)
//   rst_n        asynchronous active-low reset
//   uart_rx      serial input, idles high
//   mem_ad       BSRAM address (valid while boot_mode=1)
//   mem_din      BSRAM write data {hi, lo}
//   mem_ce       BSRAM chip enable (always enabled)
//   mem_wre      BSRAM write enable, one-cycle pulse per word
//   boot_mode    1 while loading; the top level muxes mem_ad vs CPU pc on this
//   cpu_rst_n    CPU reset, released one cycle after loading completes
//   done         image loaded successfully
//   error        framing or checksum error
//   dbg_ld_state_o / dbg_rx_state_o  current loader / receiver FSM state
// -----------------------------------------------------------------------------
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT = 234,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          ADDR_W       = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [15:0]       mem_din,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic              boot_mode,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_ld_state_o,
  output logic [1:0]        dbg_rx_state_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    L_WAIT_SYNC = 3'd0,
    L_LEN       = 3'd1,
    L_LO        = 3'd2,
    L_HI        = 3'd3,
    L_WRITE     = 3'd4,
    L_CSUM      = 3'd5,
    L_DONE      = 3'd6,
    L_ERR       = 3'd7
  } ld_state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer (idles high, so reset to 1 to avoid a false start)
  // ---------------------------------------------------------------------------
  logic rx_s1_q, rx_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver
  // Handshake: byte_valid_q is a one-cycle strobe with no ready. rx_byte
  // (shift_q) is stable from that strobe until the next data bit is sampled,
  // which is many cycles later. The consumer must take the byte on the strobe
  // cycle. frame_err_q is a one-cycle strobe on a low stop bit.
  // ---------------------------------------------------------------------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid start bit: a line already back high was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d      = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) byte_valid_d = 1'b1;
          else         frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  ld_state_e         ld_q, ld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        remain_q, remain_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        hi_q, hi_d;
  logic              cpu_rst_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q        <= L_WAIT_SYNC;
      addr_q      <= '0;
      remain_q    <= '0;
      sum_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      ld_q        <= ld_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      sum_q       <= sum_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      // The async reset supplies the "rst_n AND" term.
      cpu_rst_n_q <= ~boot_mode;
    end
  end

  always_comb begin
    ld_d     = ld_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    sum_d    = sum_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    case (ld_q)
      L_WAIT_SYNC: begin
        if (byte_valid_q && (shift_q == SYNC_BYTE)) ld_d = L_LEN;
      end
      L_LEN: begin
        if (byte_valid_q) begin
          remain_d = shift_q;
          addr_d   = '0;
          sum_d    = '0;
`ifdef BOOT_CHECKSUM_EN
          ld_d     = (shift_q == 8'd0) ? L_CSUM : L_LO;
`else
          ld_d     = (shift_q == 8'd0) ? L_DONE : L_LO;
`endif
        end
      end
      L_LO: begin
        if (byte_valid_q) begin
          lo_d  = shift_q;
          sum_d = sum_q + shift_q;
          ld_d  = L_HI;
        end
      end
      L_HI: begin
        if (byte_valid_q) begin
          hi_d  = shift_q;
          sum_d = sum_q + shift_q;
          ld_d  = L_WRITE;
        end
      end
      L_WRITE: begin
        // The write happens in this cycle. Advance to the next word.
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 8'd1;
`ifdef BOOT_CHECKSUM_EN
        ld_d     = (remain_q == 8'd1) ? L_CSUM : L_LO;
`else
        ld_d     = (remain_q == 8'd1) ? L_DONE : L_LO;
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      L_CSUM: begin
        if (byte_valid_q) ld_d = (shift_q == sum_q) ? L_DONE : L_ERR;
      end
`endif
      L_DONE: ld_d = L_DONE;
      L_ERR: begin
        if (byte_valid_q && (shift_q == SYNC_BYTE)) ld_d = L_LEN;
      end
      default: ld_d = L_WAIT_SYNC;
    endcase
    // Once the CPU has been released, line noise must not pull it back.
    if (frame_err_q && (ld_q != L_DONE)) ld_d = L_ERR;
  end

  assign mem_ad         = addr_q;
  assign mem_din        = {hi_q, lo_q};
  assign mem_ce         = 1'b1;
  assign mem_wre        = (ld_q == L_WRITE);
  assign boot_mode      = (ld_q != L_DONE);
  assign done           = (ld_q == L_DONE);
  assign error          = (ld_q == L_ERR);
  assign cpu_rst_n      = cpu_rst_n_q;
  assign dbg_ld_state_o = ld_q;
  assign dbg_rx_state_o = rx_state_q;

endmodule
